// File: rtl/rdyacpt_tx.sv
`default_nettype none
// ============================================================================
// Module      : rdyacpt_tx
// Description : rdy/acpt source that buffers strobed words and presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module rdyacpt_tx #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     rdy,
  output logic [WIDTH-1:0]         data,
  input  logic                     acpt,
  output logic                     ovf_err,
  output logic                     stall_err
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_lvl_w = c_ptr_w + 1;
  localparam int c_cnt_w = $clog2(TIMEOUT) + 1;
  localparam logic [c_lvl_w-1:0] c_full_lvl = c_lvl_w'(DEPTH);
  localparam logic [c_lvl_w-1:0] c_lvl_one  = c_lvl_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_timeout  = c_cnt_w'(TIMEOUT);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_lvl_w-1:0] r_level;
  logic               r_rdy;
  logic [WIDTH-1:0]   r_data;
  logic [c_cnt_w-1:0] r_stall_cnt;
  logic               r_ovf_err;
  logic               r_stall_err;

  logic               w_full;
  logic               w_wr_acc;
  logic               w_xfer;
  logic [c_ptr_w-1:0] w_rd_ptr_inc;
  logic [c_lvl_w-1:0] w_level_nxt;
  logic [c_cnt_w-1:0] w_stall_cnt_nxt;

  assign w_full       = (r_level == c_full_lvl);
  assign w_wr_acc     = wr_en & ~w_full;
  assign w_xfer       = r_rdy & acpt;
  assign w_rd_ptr_inc = r_rd_ptr + c_ptr_one;

  always_comb begin
    w_level_nxt = r_level;
    if (w_wr_acc && !w_xfer) begin
      w_level_nxt = r_level + c_lvl_one;
    end else if (!w_wr_acc && w_xfer) begin
      w_level_nxt = r_level - c_lvl_one;
    end
  end

  always_comb begin
    w_stall_cnt_nxt = r_stall_cnt;
    if (!r_rdy || w_xfer) begin
      w_stall_cnt_nxt = '0;
    end else if (r_stall_cnt != c_timeout) begin
      w_stall_cnt_nxt = r_stall_cnt + c_cnt_one;
    end
  end

  // Storage array needs no reset: level gates which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_rdy    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_xfer) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      r_level <= w_level_nxt;
      r_rdy   <= (w_level_nxt != '0);
    end
  end

  // Presented word is its own register so it holds its last value when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
    end else if (w_xfer) begin
      if (r_level > c_lvl_one) begin
        r_data <= r_mem[w_rd_ptr_inc];
      end else if (w_wr_acc) begin
        r_data <= wr_data;
      end
    end else if (w_wr_acc && (r_level == '0)) begin
      r_data <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_ovf_err   <= 1'b0;
      r_stall_err <= 1'b0;
    end else begin
      r_stall_cnt <= w_stall_cnt_nxt;
      if (wr_en && w_full) begin
        r_ovf_err <= 1'b1;
      end
      if (w_stall_cnt_nxt == c_timeout) begin
        r_stall_err <= 1'b1;
      end
    end
  end

  assign full      = w_full;
  assign level     = r_level;
  assign rdy       = r_rdy;
  assign data      = r_data;
  assign ovf_err   = r_ovf_err;
  assign stall_err = r_stall_err;

endmodule
`default_nettype wire

// File: tb/tb_rdyacpt_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_rdyacpt_tx
// Description : Directed self-checking bench for rdyacpt_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rdyacpt_tx;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic [2:0] level;
  logic       rdy;
  logic [7:0] data;
  logic       acpt;
  logic       ovf_err;
  logic       stall_err;

  int n_assert = 0;
  int n_fail   = 0;

  rdyacpt_tx #(.WIDTH(8), .DEPTH(4), .TIMEOUT(16)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .level     (level),
    .rdy       (rdy),
    .data      (data),
    .acpt      (acpt),
    .ovf_err   (ovf_err),
    .stall_err (stall_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    acpt    = 1'b0;
    step();
    chk("rst_rdy",   32'(rdy), 32'h0);
    chk("rst_data",  32'(data), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_full",  32'(full), 32'h0);
    chk("rst_ovf",   32'(ovf_err), 32'h0);
    chk("rst_stall", 32'(stall_err), 32'h0);
    reset = 1'b0;
    step();

    // Single word with acpt held high
    wr_en = 1'b1; wr_data = 8'hA5; acpt = 1'b1;
    step();
    chk("single_rdy",   32'(rdy), 32'h1);
    chk("single_data",  32'(data), 32'hA5);
    chk("single_level", 32'(level), 32'h1);
    wr_en = 1'b0;
    step();
    chk("single_rdy_fall", 32'(rdy), 32'h0);
    chk("single_level0",   32'(level), 32'h0);
    chk("idle_data_hold",  32'(data), 32'hA5);

    // Burst under backpressure
    acpt = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      wr_en = 1'b1; wr_data = 8'(k);
      step();
      chk("burst_level", 32'(level), 32'(k));
      chk("burst_head",  32'(data), 32'h01);
      chk("burst_rdy",   32'(rdy), 32'h1);
    end
    chk("burst_full", 32'(full), 32'h1);
    wr_en = 1'b0; acpt = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_data", 32'(data), 32'(k));
      chk("drain_rdy",  32'(rdy), 32'h1);
      step();
      chk("drain_level", 32'(level), 32'(4 - k));
    end
    chk("drain_rdy_fall", 32'(rdy), 32'h0);
    chk("drain_full_clr", 32'(full), 32'h0);

    // Overflow while a transfer happens on the same edge
    acpt = 1'b0;
    wr_en = 1'b1; wr_data = 8'h11; step();
    wr_data = 8'h22; step();
    wr_data = 8'h33; step();
    wr_data = 8'h44; step();
    chk("ovf_prefull", 32'(full), 32'h1);
    chk("ovf_pre_flag", 32'(ovf_err), 32'h0);
    wr_data = 8'hFF; acpt = 1'b1;
    step();
    chk("ovf_flag",  32'(ovf_err), 32'h1);
    chk("ovf_level", 32'(level), 32'h3);
    chk("ovf_data",  32'(data), 32'h22);
    wr_en = 1'b0;
    step();
    chk("ovf_data2", 32'(data), 32'h33);
    step();
    chk("ovf_data3", 32'(data), 32'h44);
    chk("ovf_lvl1",  32'(level), 32'h1);
    step();
    chk("ovf_empty", 32'(rdy), 32'h0);
    chk("ovf_no_ff", 32'(data), 32'h44);
    chk("ovf_sticky", 32'(ovf_err), 32'h1);

    // Stall detection
    acpt = 1'b0;
    wr_en = 1'b1; wr_data = 8'h3C;
    step();
    wr_en = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 15) chk("stall_pre", 32'(stall_err), 32'h0);
    end
    chk("stall_set",  32'(stall_err), 32'h1);
    chk("stall_data", 32'(data), 32'h3C);
    chk("stall_rdy",  32'(rdy), 32'h1);
    acpt = 1'b1;
    step();
    chk("stall_xfer",   32'(level), 32'h0);
    chk("stall_sticky", 32'(stall_err), 32'h1);

    // Write and transfer on the same edge at level 1
    acpt = 1'b0;
    wr_en = 1'b1; wr_data = 8'h10;
    step();
    chk("l1_data_a", 32'(data), 32'h10);
    wr_data = 8'h20; acpt = 1'b1;
    step();
    chk("l1_rdy",   32'(rdy), 32'h1);
    chk("l1_data",  32'(data), 32'h20);
    chk("l1_level", 32'(level), 32'h1);
    wr_en = 1'b0;
    step();
    chk("l1_done", 32'(level), 32'h0);

    // Asynchronous reset mid-burst
    acpt = 1'b0;
    wr_en = 1'b1; wr_data = 8'h5A; step();
    wr_data = 8'h6B; step();
    wr_data = 8'h7C; step();
    wr_en = 1'b0;
    chk("mid_level", 32'(level), 32'h3);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rdy",   32'(rdy), 32'h0);
    chk("async_data",  32'(data), 32'h0);
    chk("async_level", 32'(level), 32'h0);
    chk("async_ovf",   32'(ovf_err), 32'h0);
    chk("async_stall", 32'(stall_err), 32'h0);
    step();
    reset = 1'b0;
    acpt = 1'b1;
    step();
    step();
    chk("post_rst_rdy",   32'(rdy), 32'h0);
    chk("post_rst_level", 32'(level), 32'h0);
    chk("post_rst_data",  32'(data), 32'h0);
    wr_en = 1'b1; wr_data = 8'h99; acpt = 1'b0;
    step();
    wr_en = 1'b0;
    chk("post_rst_new",  32'(data), 32'h99);
    chk("post_rst_lvl1", 32'(level), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rdyacpt_tx.md
Name: rdyacpt_tx

Overview:
- Transmitting end of the rdy/acpt handshake: the source that drives rdy/data into a consumer's upstream port and waits for acpt.
- Words arrive on a simple write strobe and are buffered in a DEPTH-entry FIFO.
- The head word is presented with rdy, and held stable until acpt.
- Instantiated ahead of any block exposing a rdy/acpt upstream port. Includes overflow and stall (acpt-timeout) detection.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 4: total words held, including the presented word. Power of 2, >= 2.
- TIMEOUT, 16: consecutive stalled cycles (rdy=1, acpt=0) that set stall_err. Must be >= 1.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- wr_en  input  1  write strobe; a word is captured on posedge when wr_en=1 and full=0.
- wr_data  input  WIDTH  word to enqueue.
- full  output  1  level == DEPTH.
- level  output  $clog2(DEPTH)+1  words held (0..DEPTH), including the presented word.
- rdy  output  1  a word is presented on data.
- data  output  WIDTH  presented word.
- acpt  input  1  consumer accepts the presented word.
- ovf_err  output  1  sticky; a write was attempted while full.
- stall_err  output  1  sticky; acpt was withheld for TIMEOUT cycles.

Behaviour:
- Reset (async assert, released synchronously by the environment):
  - rdy=0, data=0, level=0, full=0, ovf_err=0, stall_err=0.
  - FIFO pointers and stall counter are 0.
  - Contents are discarded mid-operation; no word is presented after reset until a new write.
- Transfer: occurs on a posedge where rdy=1 and acpt=1. acpt while rdy=0 is ignored.
- Handshake rules (the consumer checks these):
  - Once rdy=1, it stays 1 until a transfer occurs.
  - data is constant in every cycle where rdy=1 and acpt=0.
  - data and rdy are registered outputs, with no combinational path from acpt.
- Write latency: a write at posedge N into an empty block gives rdy=1, data=wr_data from posedge N onward (visible cycle N+1).
- Ordering: strict FIFO; words are delivered exactly once, in write order.
- Throughput:
  - With acpt held high and words queued, one transfer per clock.
  - After a transfer with level>1, the next word is on data the following cycle and rdy stays 1.
- level accounting: +1 on an accepted write, -1 on a transfer, unchanged when both occur on the same edge.
- Simultaneous write and transfer at level=1: the new word becomes data next cycle, rdy stays 1, level stays 1.
- Simultaneous write and transfer at level=0: impossible, since rdy=0.
- Full condition:
  - wr_en=1 while full=1 drops the word and sets ovf_err, even if a transfer occurs on the same edge.
  - The full decision uses the pre-edge level.
- Pointers: read and write pointers wrap modulo DEPTH. level distinguishes full from empty.
- Stall counter (saturating, $clog2(TIMEOUT)+1 bits):
  - Increments each posedge with rdy=1 and acpt=0.
  - Clears to 0 on a transfer or when rdy=0.
  - When it reaches TIMEOUT, stall_err is set on that edge and stays 1 until reset.
  - The counter holds at TIMEOUT.
- Idle: with level=0, rdy=0 and data holds its last transferred value.

Test Plan:
- Single word, acpt held high: write 0xA5 at edge 1 -> rdy=1, data=0xA5 after edge 1; transfer at edge 2; rdy=0, level=0 after edge 2.
- Burst with backpressure:
  - Write 0x01..0x04 on consecutive cycles with acpt=0 -> full=1, level=4, data stays 0x01 throughout.
  - Then raise acpt -> 0x01, 0x02, 0x03, 0x04 on 4 consecutive edges; rdy falls after the 4th.
- Overflow: with full=1, assert wr_en with 0xFF and acpt=1 on the same edge -> 0xFF is never delivered, ovf_err=1, level=3.
- Stall: present 0x3C and hold acpt=0 for TIMEOUT=16 edges -> stall_err rises on the 16th edge, data stays 0x3C; a later acpt completes the transfer and stall_err stays 1.
- Level-1 concurrency: with 0x10 presented, write 0x20 on the same edge as acpt=1 -> next cycle rdy=1, data=0x20, level=1.
- Reset mid-burst: with 3 words queued and rdy=1, assert reset between edges -> rdy, data, level and flags go to 0 immediately; after release, no stale word appears.
